// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pkg
//  Description : Shared types and constants for the crop job scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
package crop_pkg;

    // Scheduler FSM states; the scheduler stores them as plain 3-bit codes
    typedef enum logic [2:0] {
        SCHED_IDLE      = 3'd0,
        SCHED_ISSUE     = 3'd1,
        SCHED_WAIT_BUSY = 3'd2,
        SCHED_WAIT_DONE = 3'd3,
        SCHED_RETIRE    = 3'd4,
        SCHED_ABORT     = 3'd5
    } sched_state_t;

    // Completion status codes reported on stat_code
    localparam logic [1:0] STAT_OK  = 2'b00;
    localparam logic [1:0] STAT_REJ = 2'b01;
    localparam logic [1:0] STAT_TMO = 2'b10;

    // One queued job: inclusive crop box plus the tag it was given on accept
    typedef struct packed {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic [1:0]  tag;
    } crop_box_t;

endpackage : crop_pkg
`default_nettype wire

// File: rtl/crop_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : crop_scheduler_if
//  Description : Host-side job request / status channel of the crop scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
interface crop_scheduler_if;

    logic        job_valid;
    logic        job_ready;
    logic [10:0] job_xmin;
    logic [10:0] job_xmax;
    logic [10:0] job_ymin;
    logic [10:0] job_ymax;
    logic        stat_valid;
    logic [1:0]  stat_tag;
    logic [1:0]  stat_code;
    logic        busy;

    // Host side: issues jobs, observes readiness and status
    modport master (
        output job_valid, job_xmin, job_xmax, job_ymin, job_ymax,
        input  job_ready, stat_valid, stat_tag, stat_code, busy
    );

    // Scheduler side
    modport slave (
        input  job_valid, job_xmin, job_xmax, job_ymin, job_ymax,
        output job_ready, stat_valid, stat_tag, stat_code, busy
    );

endinterface : crop_scheduler_if
`default_nettype wire

// File: rtl/crop_job_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : crop_job_fifo
//  Description : Synchronous FIFO of validated crop jobs with full/empty/count
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_job_fifo
    import crop_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  crop_box_t              din,
    input  wire logic              pop,
    output crop_box_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    crop_box_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W:0]       r_count;
    logic                   w_push;
    logic                   w_pop;

    // Overflow/underflow requests are ignored rather than corrupting state
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array carries no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : crop_job_fifo
`default_nettype wire

// File: rtl/crop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : crop_scheduler
//  Description : Validates and queues crop jobs, sequences the cropping engine
//                one job at a time, relocates its writes into per-job slots,
//                and reports completion / reject / watchdog-timeout status.
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_scheduler
    import crop_pkg::*;
#(
    parameter int          WIDTH      = 100,
    parameter int          HEIGHT     = 100,
    parameter int          DEPTH      = 4,
    parameter int          NUM_SLOTS  = 4,
    parameter logic [31:0] OUT_BASE   = 32'h0001_0000,
    parameter logic [31:0] SLOT_BYTES = 32'h0000_8000,
    parameter logic [23:0] TIMEOUT    = 24'd1_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    crop_scheduler_if.slave   host,
    output logic              crop_rst_n,
    output logic              crop_start,
    input  wire logic         crop_done,
    output logic [10:0]       crop_xMin,
    output logic [10:0]       crop_xMax,
    output logic [10:0]       crop_yMin,
    output logic [10:0]       crop_yMax,
    input  wire logic [31:0]  crop_writeAddr,
    input  wire logic         crop_wren,
    input  wire logic [15:0]  crop_wrdata,
    output logic [31:0]       mem_wraddr,
    output logic              mem_wren,
    output logic [15:0]       mem_wrdata
);

    localparam logic [2:0]  c_ST_IDLE      = SCHED_IDLE;
    localparam logic [2:0]  c_ST_ISSUE     = SCHED_ISSUE;
    localparam logic [2:0]  c_ST_WAIT_BUSY = SCHED_WAIT_BUSY;
    localparam logic [2:0]  c_ST_WAIT_DONE = SCHED_WAIT_DONE;
    localparam logic [2:0]  c_ST_RETIRE    = SCHED_RETIRE;
    localparam logic [2:0]  c_ST_ABORT     = SCHED_ABORT;
    localparam logic [31:0] c_WIDTH        = WIDTH;
    localparam logic [31:0] c_HEIGHT       = HEIGHT;
    localparam logic [31:0] c_SLOT_MASK    = NUM_SLOTS - 1;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [1:0]             r_tag_ctr;
    logic [1:0]             r_job_tag;
    logic                   r_rej_pending;
    logic [1:0]             r_rej_tag;
    logic                   r_abort_second;
    logic [23:0]            r_wd;

    logic                   w_accept;
    logic                   w_box_ok;
    logic                   w_push;
    logic                   w_reject;
    logic                   w_pop;
    logic                   w_waiting;
    logic                   w_timeout;
    logic                   w_retire;
    logic                   w_tmo_report;
    logic                   w_rej_report;
    logic [31:0]            w_slot;

    crop_box_t              w_fifo_din;
    crop_box_t              w_fifo_dout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;

    // ---------------------------------------------------------------- accept
    assign host.job_ready = !w_fifo_full && !r_rej_pending;
    assign w_accept       = host.job_valid && host.job_ready;
    assign w_box_ok       = (host.job_xmin <= host.job_xmax) &&
                            ({21'd0, host.job_xmax} < c_WIDTH) &&
                            (host.job_ymin <= host.job_ymax) &&
                            ({21'd0, host.job_ymax} < c_HEIGHT);
    assign w_push         = w_accept && w_box_ok;
    assign w_reject       = w_accept && !w_box_ok;
    assign w_fifo_din     = '{xmin: host.job_xmin, xmax: host.job_xmax,
                              ymin: host.job_ymin, ymax: host.job_ymax,
                              tag:  r_tag_ctr};

    crop_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_fifo_din),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Every accepted job consumes a tag, rejected ones included
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_tag_ctr <= 2'd0;
        else if (w_accept) r_tag_ctr <= r_tag_ctr + 2'd1;
    end

    // One-entry reject holding register; ready stays low until it is reported
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rej_pending <= 1'b0;
            r_rej_tag     <= 2'd0;
        end else if (w_reject) begin
            r_rej_pending <= 1'b1;
            r_rej_tag     <= r_tag_ctr;
        end else if (w_rej_report) begin
            r_rej_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ FSM
    assign w_pop        = (r_state == c_ST_IDLE) && !w_fifo_empty;
    assign w_waiting    = (r_state == c_ST_WAIT_BUSY) || (r_state == c_ST_WAIT_DONE);
    assign w_timeout    = w_waiting && (r_wd == TIMEOUT - 24'd1);
    assign w_retire     = (r_state == c_ST_RETIRE);
    assign w_tmo_report = (r_state == c_ST_ABORT) && r_abort_second;
    assign w_rej_report = r_rej_pending && !w_retire && !w_tmo_report;

    // Next-state logic; the watchdog overrides any other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (!w_fifo_empty) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE:     w_state_nxt = c_ST_WAIT_BUSY;
            c_ST_WAIT_BUSY: if (!crop_done) w_state_nxt = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: if (crop_done) w_state_nxt = c_ST_RETIRE;
            c_ST_RETIRE:    w_state_nxt = c_ST_IDLE;
            c_ST_ABORT:     if (r_abort_second) w_state_nxt = c_ST_IDLE;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = c_ST_ABORT;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Tracks which of the two ABORT cycles is current
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_abort_second <= 1'b0;
        else if (r_state == c_ST_ABORT) r_abort_second <= !r_abort_second;
        else                            r_abort_second <= 1'b0;
    end

    // Watchdog: cleared on issue, counts every cycle the engine is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_wd <= 24'd0;
        else if (r_state == c_ST_ISSUE) r_wd <= 24'd0;
        else if (w_waiting)             r_wd <= r_wd + 24'd1;
    end

    // Engine reset is low exactly during ABORT and while rst is asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crop_rst_n <= 1'b0;
        else     crop_rst_n <= (w_state_nxt != c_ST_ABORT);
    end

    // Box and tag of the current job are captured only at the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crop_xMin <= 11'd0;
            crop_xMax <= 11'd0;
            crop_yMin <= 11'd0;
            crop_yMax <= 11'd0;
            r_job_tag <= 2'd0;
        end else if (w_pop) begin
            crop_xMin <= w_fifo_dout.xmin;
            crop_xMax <= w_fifo_dout.xmax;
            crop_yMin <= w_fifo_dout.ymin;
            crop_yMax <= w_fifo_dout.ymax;
            r_job_tag <= w_fifo_dout.tag;
        end
    end

    assign crop_start = (r_state == c_ST_ISSUE);
    assign host.busy  = (r_state != c_ST_IDLE) || (w_fifo_count != '0);

    // --------------------------------------------------------------- status
    // Job completion (retire/timeout) wins; a pending reject waits its turn
    always_comb begin
        host.stat_valid = 1'b0;
        host.stat_tag   = 2'd0;
        host.stat_code  = STAT_OK;
        if (w_retire) begin
            host.stat_valid = 1'b1;
            host.stat_tag   = r_job_tag;
            host.stat_code  = STAT_OK;
        end else if (w_tmo_report) begin
            host.stat_valid = 1'b1;
            host.stat_tag   = r_job_tag;
            host.stat_code  = STAT_TMO;
        end else if (r_rej_pending) begin
            host.stat_valid = 1'b1;
            host.stat_tag   = r_rej_tag;
            host.stat_code  = STAT_REJ;
        end
    end

    // ----------------------------------------------------------- relocation
    assign w_slot     = {30'd0, r_job_tag} & c_SLOT_MASK;
    assign mem_wraddr = OUT_BASE + w_slot * SLOT_BYTES + crop_writeAddr;
    assign mem_wren   = crop_wren && w_waiting;
    assign mem_wrdata = crop_wrdata;

endmodule : crop_scheduler
`default_nettype wire

// File: tb/tb_crop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crop_scheduler
//  Description : Self-checking bench for crop_scheduler with a stub engine and
//                a queue-based model of expected job statuses
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crop_scheduler;

    typedef struct {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic [1:0]  tag;
    } job_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        crop_rst_n, crop_start, crop_done, crop_wren, mem_wren;
    logic [10:0] crop_xMin, crop_xMax, crop_yMin, crop_yMax;
    logic [31:0] crop_writeAddr, mem_wraddr;
    logic [15:0] crop_wrdata, mem_wrdata;

    crop_scheduler_if host_if ();

    crop_scheduler #(
        .TIMEOUT (24'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host           (host_if),
        .crop_rst_n     (crop_rst_n),
        .crop_start     (crop_start),
        .crop_done      (crop_done),
        .crop_xMin      (crop_xMin),
        .crop_xMax      (crop_xMax),
        .crop_yMin      (crop_yMin),
        .crop_yMax      (crop_yMax),
        .crop_writeAddr (crop_writeAddr),
        .crop_wren      (crop_wren),
        .crop_wrdata    (crop_wrdata),
        .mem_wraddr     (mem_wraddr),
        .mem_wren       (mem_wren),
        .mem_wrdata     (mem_wrdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    job_t        ok_q[$];
    logic [1:0]  rej_q[$];
    logic [1:0]  model_tag = 2'd0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Stub engine / monitor bookkeeping
    int          stub_lat    = 50;
    bit          stub_stuck  = 1'b0;
    int          start_count = 0;
    int          stat_count  = 0;
    int          rstn_low    = 0;
    int unsigned start_cyc   = 0;
    int unsigned done_cyc    = 0;
    int unsigned last_ok_cyc = 0;
    int unsigned last_rej_cyc = 0;
    logic [1:0]  cur_tag     = 2'd0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Status monitor: every pulse must match the head of the right queue
    always @(negedge clk) begin
        job_t j;
        if (!rst && !crop_rst_n) rstn_low++;
        if (host_if.stat_valid) begin
            stat_count++;
            if (host_if.stat_code == 2'b01) begin
                if (rej_q.size() == 0) check_eq("unexpected_reject", 1, 0);
                else begin
                    check_eq("reject_tag", host_if.stat_tag, rej_q.pop_front());
                    last_rej_cyc = cyc;
                end
            end else if (host_if.stat_code == 2'b00 || host_if.stat_code == 2'b10) begin
                if (ok_q.size() == 0) check_eq("unexpected_status", 1, 0);
                else begin
                    j = ok_q.pop_front();
                    if (host_if.stat_code == 2'b00) begin
                        check_eq("retire_tag", host_if.stat_tag, j.tag);
                        check_eq("retire_latency", cyc, done_cyc + 1);
                        last_ok_cyc = cyc;
                    end else begin
                        check_eq("timeout_tag", host_if.stat_tag, j.tag);
                        check_eq("timeout_latency_101_102",
                                 ((cyc - start_cyc) >= 101) && ((cyc - start_cyc) <= 102), 1);
                    end
                end
            end else begin
                check_eq("stat_code_legal", host_if.stat_code, 2'b00);
            end
        end
    end

    // Stub engine: one job per start, random writes, done rises after lat cycles
    task automatic run_engine();
        int lat;
        lat = stub_lat;
        start_count++;
        start_cyc = cyc;
        if (ok_q.size() == 0) begin
            check_eq("start_without_job", 1, 0);
            return;
        end
        cur_tag = ok_q[0].tag;
        check_eq("box_x", {crop_xMin, crop_xMax}, {ok_q[0].xmin, ok_q[0].xmax});
        check_eq("box_y", {crop_yMin, crop_yMax}, {ok_q[0].ymin, ok_q[0].ymax});
        if (stub_stuck) begin
            crop_done = 1'b1;
            return;
        end
        crop_done = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (rst) begin
                crop_done = 1'b0;
                crop_wren = 1'b0;
                return;
            end
            if (k == 1) check_eq("start_single_cycle", crop_start, 0);
            if (k == lat) begin
                crop_wren = 1'b0;
                crop_done = 1'b1;
                done_cyc  = cyc;
            end else if (k >= 2 && $urandom_range(1, 0) == 1) begin
                crop_wren      = 1'b1;
                crop_writeAddr = $urandom_range(32'h7fff, 0);
                crop_wrdata    = 16'($urandom);
                @(negedge clk);
                check_eq("wr_addr", mem_wraddr,
                         32'h0001_0000 + 32'(cur_tag) * 32'h8000 + crop_writeAddr);
                check_eq("wr_en", mem_wren, 1);
                check_eq("wr_data", mem_wrdata, crop_wrdata);
            end else begin
                crop_wren = 1'b0;
            end
        end
    endtask

    initial begin
        crop_done      = 1'b0;
        crop_wren      = 1'b0;
        crop_writeAddr = 32'd0;
        crop_wrdata    = 16'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                crop_done = 1'b0;
                crop_wren = 1'b0;
            end else if (crop_start) begin
                run_engine();
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        host_if.job_valid = 1'b0;
        ok_q.delete();
        rej_q.delete();
        model_tag = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Offer one job until accepted; the model records it at the accepting edge
    task automatic send_job(input logic [10:0] x0, input logic [10:0] x1,
                            input logic [10:0] y0, input logic [10:0] y1);
        bit   acc;
        job_t j;
        acc = 1'b0;
        host_if.job_valid = 1'b1;
        host_if.job_xmin  = x0;
        host_if.job_xmax  = x1;
        host_if.job_ymin  = y0;
        host_if.job_ymax  = y1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            if (host_if.job_ready) begin
                if (x0 <= x1 && x1 < 100 && y0 <= y1 && y1 < 100) begin
                    j.xmin = x0; j.xmax = x1; j.ymin = y0; j.ymax = y1; j.tag = model_tag;
                    ok_q.push_back(j);
                end else begin
                    rej_q.push_back(model_tag);
                end
                model_tag = model_tag + 2'd1;
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        host_if.job_valid = 1'b0;
        if (!acc) check_eq("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ok_q.size() == 0 && rej_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check_eq("drain_outstanding", ok_q.size() + rej_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, r0;
        rst = 1'b1;
        host_if.job_valid = 1'b0;
        host_if.job_xmin  = 11'd0;
        host_if.job_xmax  = 11'd0;
        host_if.job_ymin  = 11'd0;
        host_if.job_ymax  = 11'd0;

        // Reset values
        @(negedge clk);
        check_eq("rst_job_ready", host_if.job_ready, 1);
        check_eq("rst_stat", {host_if.stat_valid, host_if.stat_tag, host_if.stat_code}, 0);
        check_eq("rst_busy", host_if.busy, 0);
        check_eq("rst_crop_rst_n", crop_rst_n, 0);
        check_eq("rst_crop_start", crop_start, 0);
        check_eq("rst_box", {crop_xMin, crop_xMax, crop_yMin, crop_yMax}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_n_before_first_clk", crop_rst_n, 0);
        @(posedge clk); #1;
        check_eq("rst_n_after_first_clk", crop_rst_n, 1);

        // Single job, tag 0, slot 0
        stub_lat = 50;
        s0 = start_count;
        send_job(11'd10, 11'd19, 11'd5, 11'd9);
        wait_drain(300);
        check_eq("single_start_count", start_count - s0, 1);

        // Invalid box: rejected with tag 0, next valid job takes tag 1
        do_reset();
        s0 = start_count;
        send_job(11'd20, 11'd10, 11'd5, 11'd9);
        @(negedge clk);
        check_eq("ready_low_reject_pending", host_if.job_ready, 0);
        wait_drain(50);
        check_eq("reject_no_start", start_count - s0, 0);
        send_job(11'd1, 11'd2, 11'd3, 11'd4);
        wait_drain(300);
        check_eq("after_reject_start", start_count - s0, 1);

        // Five back-to-back jobs fill the FIFO; tags 0,1,2,3,0
        do_reset();
        for (int n = 0; n < 5; n++) send_job(11'(n), 11'(n + 50), 11'(2 * n), 11'(99));
        @(negedge clk);
        check_eq("ready_low_fifo_full", host_if.job_ready, 0);
        check_eq("busy_with_queue", host_if.busy, 1);
        wait_drain(800);

        // Watchdog: done stuck high
        do_reset();
        stub_stuck = 1'b1;
        r0 = rstn_low;
        send_job(11'd0, 11'd99, 11'd0, 11'd99);
        wait_drain(400);
        check_eq("abort_rst_n_low_cycles", rstn_low - r0, 2);
        stub_stuck = 1'b0;

        // Reject handshake in the cycle done rises: retire first, reject next
        do_reset();
        stub_lat = 20;
        send_job(11'd0, 11'd9, 11'd0, 11'd9);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (crop_done) break;
        end
        check_eq("done_seen", crop_done, 1);
        send_job(11'd30, 11'd5, 11'd0, 11'd0);
        wait_drain(100);
        check_eq("reject_after_retire", last_rej_cyc, last_ok_cyc + 1);

        // Reset in the middle of a job
        do_reset();
        stub_lat = 60;
        send_job(11'd2, 11'd3, 11'd4, 11'd5);
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        ok_q.delete();
        rej_q.delete();
        model_tag = 2'd0;
        #1;
        check_eq("midrst_crop_rst_n", crop_rst_n, 0);
        check_eq("midrst_ready", host_if.job_ready, 1);
        check_eq("midrst_stat_valid", host_if.stat_valid, 0);
        check_eq("midrst_busy", host_if.busy, 0);
        check_eq("midrst_start", crop_start, 0);
        check_eq("midrst_box", {crop_xMin, crop_xMax, crop_yMin, crop_yMax}, 0);
        check_eq("midrst_mem_wren", mem_wren, 0);
        s0 = stat_count;
        r0 = start_count;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_no_status", stat_count - s0, 0);
        check_eq("midrst_no_start", start_count - r0, 0);
        check_eq("midrst_idle", host_if.busy, 0);
        @(posedge clk); #1;

        // Randomized mix of valid and invalid jobs
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [10:0] x0, x1, y0, y1;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
            stub_lat = $urandom_range(30, 2);
            if ($urandom_range(3, 0) != 0) begin
                x0 = 11'($urandom_range(99, 0));
                x1 = 11'($urandom_range(99, int'(x0)));
                y0 = 11'($urandom_range(99, 0));
                y1 = 11'($urandom_range(99, int'(y0)));
            end else begin
                x0 = 11'($urandom);
                x1 = 11'($urandom);
                y0 = 11'($urandom_range(99, 0));
                y1 = 11'($urandom_range(2047, 100));
            end
            send_job(x0, x1, y0, y1);
        end
        wait_drain(5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule : tb_crop_scheduler
`default_nettype wire
